// File: rtl/side_buffer_dual_wr_if.sv
// Side buffer port bundle: two write sources, inject pop, status.
// master = upstream router logic, slave = the side buffer itself.
interface side_buffer_dual_wr_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             redirect_vld;
    logic [WIDTH-1:0] din_redirect;
    logic             deflect_vld;
    logic [WIDTH-1:0] din_deflect;
    logic             inject_gnt;
    logic [WIDTH-1:0] dout_inject;
    logic             empty;
    logic             full;
    logic             afull;
    logic [CW-1:0]    count;
    logic             starve;
    logic             overflow_err;

    modport master (
        output redirect_vld, din_redirect,
        output deflect_vld, din_deflect,
        output inject_gnt,
        input  dout_inject, empty, full, afull,
        input  count, starve, overflow_err
    );

    modport slave (
        input  redirect_vld, din_redirect,
        input  deflect_vld, din_deflect,
        input  inject_gnt,
        output dout_inject, empty, full, afull,
        output count, starve, overflow_err
    );
endinterface

// File: rtl/side_buffer_dual_wr.sv
// MinBD side buffer taking redirect and failed-eject flits in one cycle.
// FIFO re-injection with starvation flag and sticky overflow error.
`ifndef WIDTH_FLIT_INT
`define WIDTH_FLIT_INT 32
`endif

module side_buffer_dual_wr #(
    parameter int WIDTH     = `WIDTH_FLIT_INT,
    parameter int DEPTH     = 4,
    parameter int STARVE_TH = 8
) (
    input logic clk,
    input logic n_rst,
    side_buffer_dual_wr_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_TH + 1);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);
    localparam logic [SW-1:0] TH_C    = SW'(STARVE_TH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] scnt;
    logic          ovf;

    logic [PW-1:0] wr_ptr1;
    logic [PW-1:0] wr_ptr2;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr1;
    logic [PW-1:0] dfl_ptr;
    logic [CW-1:0] free;
    logic [1:0]    n_wr;
    logic          acc_r;
    logic          acc_d;
    logic          drop;
    logic          pop;
    logic          empty;

    // Circular increment; no power-of-two depth assumed.
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    assign empty = (count == '0);
    assign free  = DEPTH_C - count;
    assign pop   = bus.inject_gnt && !empty;

    assign wr_ptr1 = inc(wr_ptr);
    assign wr_ptr2 = inc(wr_ptr1);
    assign rd_ptr1 = inc(rd_ptr);

    // Admission: redirect is older and wins the last free slot.
    always_comb begin
        acc_r = 1'b0;
        acc_d = 1'b0;
        if (bus.redirect_vld) begin
            acc_r = (free >= CW'(1));
            acc_d = bus.deflect_vld && (free >= CW'(2));
        end else begin
            acc_d = bus.deflect_vld && (free >= CW'(1));
        end
    end

    assign drop = (bus.redirect_vld && !acc_r)
                || (bus.deflect_vld && !acc_d);
    assign n_wr = {1'b0, acc_r} + {1'b0, acc_d};
    assign dfl_ptr = acc_r ? wr_ptr1 : wr_ptr;

    // Write pointer advances by the number of flits accepted.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        unique case (n_wr)
            2'd1:    wr_ptr_nxt = wr_ptr1;
            2'd2:    wr_ptr_nxt = wr_ptr2;
            default: wr_ptr_nxt = wr_ptr;
        endcase
    end

    // Flit storage; contents survive reset, only pointers are cleared.
    always_ff @(posedge clk) begin
        if (acc_r) mem[wr_ptr] <= bus.din_redirect;
        if (acc_d) mem[dfl_ptr] <= bus.din_deflect;
    end

    // Pointers and occupancy; a pop never frees a slot for this cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            if (pop) rd_ptr <= rd_ptr1;
            count <= count + CW'(n_wr) - CW'(pop);
        end
    end

    // Saturating head-wait counter, cleared by empty or a grant.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scnt <= '0;
        end else if (empty || bus.inject_gnt) begin
            scnt <= '0;
        end else if (scnt < TH_C) begin
            scnt <= scnt + SW'(1);
        end
    end

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end

    assign bus.dout_inject  = empty ? '0 : mem[rd_ptr];
    assign bus.empty        = empty;
    assign bus.full         = (count == DEPTH_C);
    assign bus.afull        = (count >= DEPTH_C - CW'(1));
    assign bus.count        = count;
    assign bus.starve       = !empty && (scnt >= TH_C);
    assign bus.overflow_err = ovf;

`ifndef SYNTHESIS
    // Occupancy and pointers must stay inside the array.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            assert (count <= DEPTH_C);
            assert (wr_ptr <= LAST_C);
            assert (rd_ptr <= LAST_C);
        end
    end
`endif

endmodule
